// File: rtl/spi_regbank_pkg.sv
// Shared types and constants for the SPI register-bank peripheral.
// Frame layout: one rw bit, ADDR_W address bits, then DATA_W-bit words, all MSB first.
package spi_regbank_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        HEADER = 2'd1,
        DATA   = 2'd2
    } state_t;

    localparam logic RW_WRITE = 1'b1;
    localparam logic RW_READ  = 1'b0;

    function automatic int header_bits(input int addr_w);
        return addr_w + 1;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser for an asynchronous input, with one extra flop for
// rise/fall detection on the synchronised level.
module spi_sync_edge #(
    parameter int   STAGES = 2,
    parameter logic INIT   = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    // NOTE: registers use non-blocking assignments so every flop samples the pre-edge value of its neighbour.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain <= {STAGES{INIT}};
            prev  <= INIT;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/spi_regbank_peripheral.sv
// SPI mode-0 peripheral exposing NUM_REGS read/write configuration registers,
// with burst auto-increment, per-word commit and address/frame error pulses.
module spi_regbank_peripheral
    import spi_regbank_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int ADDR_W      = 7,
    parameter int SYNC_STAGES = 2,
    parameter int BURST_EN    = 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       spi_sclk,
    input  logic                       spi_copi,
    input  logic                       spi_cs_n,
    output logic                       spi_cipo,
    output logic                       spi_cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_o,
    output logic                       wr_stb_o,
    output logic [ADDR_W-1:0]          wr_addr_o,
    output logic [DATA_W-1:0]          wr_data_o,
    output logic                       addr_err_o,
    output logic                       frame_err_o
);

    localparam int HDR_BITS = header_bits(ADDR_W);
    localparam int SHIFT_W  = (HDR_BITS > DATA_W) ? HDR_BITS : DATA_W;
    localparam int CNT_W    = $clog2(SHIFT_W);
    localparam int AW1      = ADDR_W + 1;
    localparam logic [CNT_W-1:0] HDR_LAST  = CNT_W'(HDR_BITS - 1);
    localparam logic [CNT_W-1:0] WORD_LAST = CNT_W'(DATA_W - 1);
    localparam logic [AW1-1:0]   REG_LIMIT = AW1'(NUM_REGS);

    logic sclk_rise, sclk_fall, sclk_level_unused;
    logic cs_level, cs_rise, cs_fall;
    logic copi_s, copi_rise_unused, copi_fall_unused;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_sclk_sync (
        .clk(clk), .rst_n(rst_n), .din(spi_sclk),
        .level(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall)
    );

    // cs_n idles high, so its chain resets high to avoid a phantom select after reset.
    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b1)) u_cs_sync (
        .clk(clk), .rst_n(rst_n), .din(spi_cs_n),
        .level(cs_level), .rise(cs_rise), .fall(cs_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .INIT(1'b0)) u_copi_sync (
        .clk(clk), .rst_n(rst_n), .din(spi_copi),
        .level(copi_s), .rise(copi_rise_unused), .fall(copi_fall_unused)
    );

    state_t              state;
    logic [CNT_W-1:0]    bit_cnt;
    logic [SHIFT_W-2:0]  shift_in;
    logic                rw;
    logic [ADDR_W-1:0]   addr;
    logic [DATA_W-1:0]   rd_shift;
    logic                halted;

    logic [SHIFT_W-1:0]  next_shift;
    logic                hdr_rw;
    logic [ADDR_W-1:0]   hdr_addr;
    logic [ADDR_W-1:0]   addr_inc;
    logic [DATA_W-1:0]   word;

    // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
    always_comb begin
        next_shift = {shift_in, copi_s};
        hdr_rw     = next_shift[ADDR_W];
        hdr_addr   = next_shift[ADDR_W-1:0];
        word       = next_shift[DATA_W-1:0];
        addr_inc   = addr + ADDR_W'(1);
    end

    function automatic logic in_range(input logic [ADDR_W-1:0] a);
        return {1'b0, a} < REG_LIMIT;
    endfunction

    function automatic logic [DATA_W-1:0] reg_at(input logic [ADDR_W-1:0] a);
        logic [DATA_W-1:0] v;
        v = '0;
        for (int k = 0; k < NUM_REGS; k++)
            if (a == ADDR_W'(k)) v = regs_o[k*DATA_W +: DATA_W];
        return v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            bit_cnt     <= '0;
            shift_in    <= '0;
            rw          <= RW_READ;
            addr        <= '0;
            rd_shift    <= '0;
            halted      <= 1'b0;
            spi_cipo    <= 1'b0;
            spi_cipo_oe <= 1'b0;
            // NOTE: the register bank is an output with defined power-up values, so it is reset like any control flop.
            regs_o      <= '0;
            wr_stb_o    <= 1'b0;
            wr_addr_o   <= '0;
            wr_data_o   <= '0;
            addr_err_o  <= 1'b0;
            frame_err_o <= 1'b0;
        end else begin
            wr_stb_o    <= 1'b0;
            addr_err_o  <= 1'b0;
            frame_err_o <= 1'b0;
            spi_cipo_oe <= ~cs_level;

            if (cs_rise) begin
                // Deselect on a header/word boundary is clean; anything else drops the partial word.
                if (state != IDLE && bit_cnt != '0) frame_err_o <= 1'b1;
                state    <= IDLE;
                bit_cnt  <= '0;
                halted   <= 1'b0;
                spi_cipo <= 1'b0;
            end else if (cs_fall) begin
                state    <= HEADER;
                bit_cnt  <= '0;
                shift_in <= '0;
                halted   <= 1'b0;
                spi_cipo <= 1'b0;
            end else begin
                case (state)
                    HEADER: begin
                        if (sclk_rise) begin
                            shift_in <= next_shift[SHIFT_W-2:0];
                            if (bit_cnt == HDR_LAST) begin
                                rw       <= hdr_rw;
                                addr     <= hdr_addr;
                                bit_cnt  <= '0;
                                state    <= DATA;
                                rd_shift <= reg_at(hdr_addr);
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end
                    end
                    DATA: begin
                        if (halted) begin
                            // Single-word mode: wait for deselect.
                        end else if (sclk_rise) begin
                            shift_in <= next_shift[SHIFT_W-2:0];
                            if (bit_cnt == WORD_LAST) begin
                                bit_cnt <= '0;
                                if (!in_range(addr)) begin
                                    addr_err_o <= 1'b1;
                                end else if (rw == RW_WRITE) begin
                                    for (int k = 0; k < NUM_REGS; k++)
                                        if (addr == ADDR_W'(k)) regs_o[k*DATA_W +: DATA_W] <= word;
                                    wr_stb_o  <= 1'b1;
                                    wr_addr_o <= addr;
                                    wr_data_o <= word;
                                end
                                if (BURST_EN != 0) begin
                                    addr     <= addr_inc;
                                    rd_shift <= reg_at(addr_inc);
                                end else begin
                                    halted <= 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + CNT_W'(1);
                            end
                        end else if (sclk_fall && rw == RW_READ) begin
                            spi_cipo <= rd_shift[DATA_W-1];
                            rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule
